dcache_assoc: RTL
=================

Name: dcache_assoc

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache. It is the successor of the direct-mapped dcache and sits between the cpu load/store port and data_memory.
- Same busywait handshake on both sides as the current cache.
- Adds configurable sets, ways and block size, true-LRU replacement, and saturating hit/miss performance counters.

Parameters:
ADDR_W, 8, CPU byte-address width
BLOCK_BYTES, 4, bytes per block (power of 2); memory bus width = 8*BLOCK_BYTES
SETS, 8, number of sets (power of 2)
WAYS, 2, associativity (power of 2, 1..8)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
read  in  1  CPU load request; held stable while busywait=1
write  in  1  CPU store request; held stable while busywait=1
address  in  ADDR_W  CPU byte address
writedata  in  8  store data
readdata  out  8  load data
busywait  out  1  CPU stall
mem_read  out  1  block read request to memory
mem_write  out  1  block write request to memory
mem_address  out  ADDR_W-OFF_W  block address, {tag,index}
mem_writedata  out  8*BLOCK_BYTES  evicted block
mem_readdata  in  8*BLOCK_BYTES  refill block
mem_busywait  in  1  memory busy; transfer completes on edge where it is 0 with a request asserted
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
Address split:
- OFF_W=log2(BLOCK_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W.
- address = {tag,index,offset}.
- Byte k of a block occupies bits [8k+7:8k] (little-endian).

Reset (reset=0 at rising edge):
- All valid/dirty bits cleared; LRU ages set to way number; state IDLE; counters 0.
- Outputs: busywait=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, readdata=0.
- Reset mid-transaction aborts it on that same edge. Dirty data is lost.

States: IDLE, WRITE_BACK, MEM_READ.
- IDLE, read hit: readdata is combinational from the hitting way; busywait=0; LRU updated at the edge.
- IDLE, write hit: busywait=0; byte written and dirty=1 at the edge; LRU updated.
- IDLE, miss: busywait=1 combinationally.
  - Victim = lowest-index invalid way, else the way with the maximum age.
  - Victim valid and dirty -> WRITE_BACK; otherwise -> MEM_READ.
- WRITE_BACK: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim block. On an edge with mem_busywait=0 -> MEM_READ.
- MEM_READ: mem_read=1, mem_address={req tag,index}.
  - On an edge with mem_busywait=0: victim data=mem_readdata, tag written, valid=1, dirty=0; -> IDLE.
  - The request then completes as a hit in the next cycle (busywait=0).
- busywait stays 1 from miss detection through the end of MEM_READ.
- Memory requests are driven from the registered state, so they are glitch-free.

LRU (age per way, log2(WAYS) bits):
- On access to way w, age[w] becomes 0.
- Every way whose age was less than the old age[w] increments by 1.
- Ages in a set always form a permutation of 0..WAYS-1.

Counters:
- miss_count +1 per miss detected in IDLE.
- hit_count +1 per request hitting in IDLE, but not for the post-refill completion cycle (a pending-miss flag suppresses it).
- Both counters saturate at all-ones.

Edge cases:
- read and write both asserted: treated as write.
- Request dropped mid-miss: the memory transaction still completes, then IDLE.
- WAYS=1 degenerates to direct-mapped (no LRU storage).

Decomposition:
- Package dcache_pkg: state enum (IDLE, WRITE_BACK, MEM_READ) and the localparam derivation functions for OFF_W, IDX_W and TAG_W.
- Sub-module dcache_lru (per-set age array; victim select plus update on access), instantiated once, indexed by set.
- Tag/data/valid/dirty arrays live in dcache_assoc.

Test Plan:
All scenarios use default parameters unless stated. Memory model has a 5-cycle busywait.
- Cold read 0x05 after reset -> busywait=1, mem_read=1, mem_address=6'h01. Memory returns 32'hDDCCBBAA -> readdata=8'hBB, busywait drops one cycle after refill, miss_count=1, hit_count=0.
- Write 0x06=8'h5A then read 0x06 (after the 0x05 fill) -> no busywait on either access, readdata=8'h5A, hit_count=2, no mem_write.
- Clean eviction: reads 0x05, 0x25, 0x05, then 0x45 -> the 0x45 miss evicts the tag-1 way with no write-back; mem_read mem_address=6'h11; subsequent read 0x05 hits.
- Dirty eviction: write 0x05=8'h77, read 0x25, read 0x45 -> mem_write=1, mem_address=6'h01, mem_writedata=32'hDDCC77AA, then mem_read mem_address=6'h11.
- Reset mid-miss: reset=0 for one edge during MEM_READ -> mem_read=0, busywait=0, counters=0 after that edge; re-read of 0x05 misses again.
- Saturation with CNT_W=4: one miss then 20 hits to 0x05 -> hit_count=4'hF, miss_count=4'h1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache.
// Latency: n/a (package only).
// Backpressure: n/a.
package dcache_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WRITE_BACK = 2'd1;
    localparam logic [1:0] ST_MEM_READ   = 2'd2;

    function automatic int off_w(input int block_bytes);
        return $clog2(block_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int block_bytes);
        return addr_w - idx_w(sets) - off_w(block_bytes);
    endfunction

    // Way index width; kept at least 1 bit so a direct-mapped build still has a legal vector
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_assoc_if.sv
// CPU load/store port and block memory port of the data cache, bundled.
// Latency: n/a (wiring only).
// Backpressure: busywait toward the cpu, mem_busywait from memory.
// Ports: slave = cache view, master = cpu + memory view.
interface dcache_assoc_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int BLOCK_BYTES = 4
);
    localparam int MA_W = ADDR_W - off_w(BLOCK_BYTES);
    localparam int MD_W = 8 * BLOCK_BYTES;

    // cpu side
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [7:0]        writedata;
    logic [7:0]        readdata;
    logic              busywait;
    // memory side
    logic              mem_read;
    logic              mem_write;
    logic [MA_W-1:0]   mem_address;
    logic [MD_W-1:0]   mem_writedata;
    logic [MD_W-1:0]   mem_readdata;
    logic              mem_busywait;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/dcache_lru.sv
// True-LRU age tracker, one age per way per set; reports the oldest way of the indexed set.
// Latency: oldest is combinational from set_idx; ages update on the edge where acc=1.
// Backpressure: none; acc is a one-cycle strobe.
// Ports: clk, reset (sync, active-low), set_idx, acc, acc_way, oldest.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [idx_w(SETS)-1:0]   set_idx,
    input  logic                     acc,
    input  logic [way_w(WAYS)-1:0]   acc_way,
    output logic [way_w(WAYS)-1:0]   oldest
);
    localparam int WAY_W = way_w(WAYS);

    generate
        if (WAYS == 1) begin : g_dm
            assign oldest = '0;
        end else begin : g_lru
            logic [WAY_W-1:0] age_q [SETS][WAYS];

            // Ages are a permutation, so the oldest way is the one holding WAYS-1
            always_comb begin
                oldest = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) oldest = WAY_W'(w);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int s = 0; s < SETS; s++)
                        for (int w = 0; w < WAYS; w++)
                            age_q[s][w] <= WAY_W'(w);
                end else if (acc) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == acc_way)
                            age_q[set_idx][w] <= '0;
                        else if (age_q[set_idx][w] < age_q[set_idx][acc_way])
                            age_q[set_idx][w] <= age_q[set_idx][w] + WAY_W'(1);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU and hit/miss counters.
// Latency: hits complete in the request cycle; misses stall for write-back (if dirty) + refill + 1.
// Backpressure: busywait holds the cpu from miss detection to end of refill; waits on mem_busywait.
// Ports: clk, reset (sync, active-low), bus (dcache_assoc_if.slave), hit_count, miss_count.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int BLOCK_BYTES = 4,
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    dcache_assoc_if.slave    bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int OFF_W = off_w(BLOCK_BYTES);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, BLOCK_BYTES);
    localparam int WAY_W = way_w(WAYS);
    localparam int BLK_W = 8 * BLOCK_BYTES;

    logic [TAG_W-1:0] tag_q  [SETS][WAYS];
    logic [BLK_W-1:0] data_q [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];

    logic [1:0]       state_q;
    logic             fill_done_q;   // set for the completion cycle right after a refill
    logic [IDX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0] miss_tag_q;
    logic [TAG_W-1:0] vic_tag_q;
    logic [WAY_W-1:0] vic_way_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic             req, hit, idle_hit, idle_miss, inv_found;
    logic [WAY_W-1:0] hit_way, vic_way, lru_oldest;
    logic [BLK_W-1:0] hit_blk;

    assign req_tag   = bus.address[ADDR_W-1 -: TAG_W];
    assign idx       = bus.address[OFF_W +: IDX_W];
    assign off       = bus.address[OFF_W-1:0];
    assign req       = bus.read | bus.write;
    assign idle_hit  = (state_q == ST_IDLE) && req && hit;
    assign idle_miss = (state_q == ST_IDLE) && req && !hit;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vic_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Scan downward so the lowest-index invalid way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        if (!inv_found) vic_way = lru_oldest;
    end

    dcache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .clk     (clk),
        .reset   (reset),
        .set_idx (idx),
        .acc     (idle_hit),
        .acc_way (hit_way),
        .oldest  (lru_oldest)
    );

    assign hit_blk      = data_q[idx][hit_way];
    assign bus.readdata = (idle_hit && bus.read) ? hit_blk[{off, 3'b000} +: 8] : 8'h00;
    assign bus.busywait = (state_q != ST_IDLE) || idle_miss;

    // Memory requests come straight from registered state
    always_comb begin
        bus.mem_read      = (state_q == ST_MEM_READ);
        bus.mem_write     = (state_q == ST_WRITE_BACK);
        bus.mem_address   = '0;
        bus.mem_writedata = '0;
        if (state_q == ST_WRITE_BACK) begin
            bus.mem_address   = {vic_tag_q, miss_idx_q};
            bus.mem_writedata = data_q[miss_idx_q][vic_way_q];
        end else if (state_q == ST_MEM_READ) begin
            bus.mem_address   = {miss_tag_q, miss_idx_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fill_done_q <= 1'b0;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
            vic_tag_q   <= '0;
            vic_way_q   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    fill_done_q <= 1'b0;
                    if (idle_hit) begin
                        if (bus.write) begin
                            data_q[idx][hit_way][{off, 3'b000} +: 8] <= bus.writedata;
                            dirty_q[idx][hit_way] <= 1'b1;
                        end
                        if (!fill_done_q && !(&hit_count))
                            hit_count <= hit_count + CNT_W'(1);
                    end
                    if (idle_miss) begin
                        miss_idx_q <= idx;
                        miss_tag_q <= req_tag;
                        vic_way_q  <= vic_way;
                        vic_tag_q  <= tag_q[idx][vic_way];
                        if (!(&miss_count))
                            miss_count <= miss_count + CNT_W'(1);
                        state_q <= (valid_q[idx][vic_way] && dirty_q[idx][vic_way])
                                   ? ST_WRITE_BACK : ST_MEM_READ;
                    end
                end
                ST_WRITE_BACK: begin
                    if (!bus.mem_busywait) state_q <= ST_MEM_READ;
                end
                ST_MEM_READ: begin
                    if (!bus.mem_busywait) begin
                        data_q[miss_idx_q][vic_way_q]  <= bus.mem_readdata;
                        tag_q[miss_idx_q][vic_way_q]   <= miss_tag_q;
                        valid_q[miss_idx_q][vic_way_q] <= 1'b1;
                        dirty_q[miss_idx_q][vic_way_q] <= 1'b0;
                        fill_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
